// File: rtl/intel_vvp_exposure_fusion_pkg.sv
// Shared types and helpers for the dual-exposure deinterleave path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package intel_vvp_exposure_fusion_pkg;

   // Deinterleaver control states: hunting for a frame start, or routing lines.
   typedef enum logic {
      ST_WAIT_SOF = 1'b0,
      ST_ACTIVE   = 1'b1
   } dil_state_e;

   // tuser bit that flags the first beat of a frame.
   localparam int TUSER_SOF_BIT = 0;

   // AXI4-Stream data width: each pixel padded up to whole bytes, times pixels per beat.
   function automatic int axis_width(input int planes, input int bps, input int pip);
      return ((planes * bps + 7) / 8 * 8) * pip;
   endfunction

endpackage

// File: rtl/intel_vvp_exposure_deinterleave_slice.sv
// One-entry output register slice for a single exposure stream.
// Latency: 1 cycle from load to tvalid.
// Backpressure: holds its beat stable while tready is low; caller loads only when empty or draining.
module intel_vvp_exposure_deinterleave_slice #(
   parameter int DATA_W = 32,
   parameter int USER_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] tdata_i,
   input  logic              tlast_i,
   input  logic [USER_W-1:0] tuser_i,
   input  logic              tready_i,
   output logic              tvalid_o,
   output logic [DATA_W-1:0] tdata_o,
   output logic              tlast_o,
   output logic [USER_W-1:0] tuser_o
);

   logic              vld_q;
   logic [DATA_W-1:0] data_q;
   logic              last_q;
   logic [USER_W-1:0] user_q;

   // Occupancy: a new load wins over a drain, so back-to-back beats stream at full rate.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= 1'b0;
      end else if (load_i) begin
         vld_q <= 1'b1;
      end else if (tready_i) begin
         vld_q <= 1'b0;
      end
   end

   // Payload is captured only on load, which keeps it frozen while the consumer stalls.
   always_ff @(posedge clk_i) begin
      if (load_i) begin
         data_q <= tdata_i;
         last_q <= tlast_i;
         user_q <= tuser_i;
      end
   end

   assign tvalid_o = vld_q;
   assign tdata_o  = data_q;
   assign tlast_o  = last_q;
   assign tuser_o  = user_q;

endmodule

// File: rtl/intel_vvp_exposure_deinterleave.sv
// Splits a line-interleaved dual-exposure video stream into long (out_0) and short (out_1) streams.
// Latency: 1 cycle from input acceptance to output tvalid.
// Backpressure: input stalls only when the slice the current beat targets is full and not draining.
module intel_vvp_exposure_deinterleave
   import intel_vvp_exposure_fusion_pkg::*;
#(
   parameter int NUMBER_OF_COLOR_PLANES = 1,
   parameter int PIXELS_IN_PARALLEL     = 2,
   parameter int BPS                    = 12,
   parameter int C_FIRST_LINE_EXPOSURE  = 0,
   localparam int C_AXIS_WIDTH  = axis_width(NUMBER_OF_COLOR_PLANES, BPS, PIXELS_IN_PARALLEL),
   localparam int C_TUSER_WIDTH = C_AXIS_WIDTH / 8
) (
   input  logic                     main_clock,
   input  logic                     main_reset,

   input  logic [C_AXIS_WIDTH-1:0]  axi4s_vid_in_tdata,
   input  logic                     axi4s_vid_in_tlast,
   input  logic [C_TUSER_WIDTH-1:0] axi4s_vid_in_tuser,
   input  logic                     axi4s_vid_in_tvalid,
   output logic                     axi4s_vid_in_tready,

   output logic [C_AXIS_WIDTH-1:0]  axi4s_vid_out_0_tdata,
   output logic                     axi4s_vid_out_0_tlast,
   output logic [C_TUSER_WIDTH-1:0] axi4s_vid_out_0_tuser,
   output logic                     axi4s_vid_out_0_tvalid,
   input  logic                     axi4s_vid_out_0_tready,

   output logic [C_AXIS_WIDTH-1:0]  axi4s_vid_out_1_tdata,
   output logic                     axi4s_vid_out_1_tlast,
   output logic [C_TUSER_WIDTH-1:0] axi4s_vid_out_1_tuser,
   output logic                     axi4s_vid_out_1_tvalid,
   input  logic                     axi4s_vid_out_1_tready,

   output logic                     status_sof_error
);

   localparam logic FIRST_SEL = (C_FIRST_LINE_EXPOSURE != 0);

   dil_state_e               state_q, state_d;
   logic                     sel_q, sel_d;
   logic [1:0]               pend_q, pend_d;
   logic                     first_beat_q, first_beat_d;
   logic                     err_q, err_d;

   logic                     in_sof;
   logic                     route_sel;
   logic                     accept;
   logic [1:0]               pend_nxt;
   logic [1:0]               load;
   logic [1:0]               slc_vld;
   logic [1:0]               slc_rdy;
   logic [C_TUSER_WIDTH-1:0] fwd_user;

   assign in_sof  = axi4s_vid_in_tuser[TUSER_SOF_BIT];
   assign slc_rdy = {axi4s_vid_out_1_tready, axi4s_vid_out_0_tready};

   // An SOF beat always restarts on the first-line output, so readiness is judged against
   // the output this beat will actually land in (decided by tuser, never by tvalid).
   assign route_sel = in_sof ? FIRST_SEL : sel_q;

   // Control state register.
   always_ff @(posedge main_clock) begin
      if (main_reset) begin
         state_q      <= ST_WAIT_SOF;
         sel_q        <= FIRST_SEL;
         pend_q       <= 2'b00;
         first_beat_q <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         pend_q       <= pend_d;
         first_beat_q <= first_beat_d;
         err_q        <= err_d;
      end
   end

   // Next-state, input ready, slice loads and forwarded SOF flag.
   always_comb begin
      state_d             = state_q;
      sel_d               = sel_q;
      pend_d              = pend_q;
      pend_nxt            = pend_q;
      first_beat_d        = first_beat_q;
      err_d               = 1'b0;
      load                = 2'b00;
      axi4s_vid_in_tready = 1'b0;
      fwd_user            = axi4s_vid_in_tuser;

      case (state_q)
         ST_WAIT_SOF: axi4s_vid_in_tready = 1'b1;
         ST_ACTIVE:   axi4s_vid_in_tready = !slc_vld[route_sel] || slc_rdy[route_sel];
         default:     axi4s_vid_in_tready = 1'b0;
      endcase
      if (main_reset) begin
         axi4s_vid_in_tready = 1'b0;
      end

      accept = axi4s_vid_in_tvalid && axi4s_vid_in_tready;

      // Beats before the first SOF are swallowed; everything after is routed.
      if (accept && ((state_q == ST_ACTIVE) || in_sof)) begin
         load[route_sel] = 1'b1;
         if (in_sof) begin
            state_d  = ST_ACTIVE;
            // An SOF landing mid-line means the previous line was cut short.
            err_d    = (state_q == ST_ACTIVE) && !first_beat_q;
            pend_nxt = 2'b11;
         end
         fwd_user[TUSER_SOF_BIT] = pend_nxt[route_sel];
         pend_d                  = pend_nxt;
         pend_d[route_sel]       = 1'b0;
         sel_d                   = route_sel ^ axi4s_vid_in_tlast;
         first_beat_d            = axi4s_vid_in_tlast;
      end
   end

   assign status_sof_error = err_q;

   intel_vvp_exposure_deinterleave_slice #(
      .DATA_W (C_AXIS_WIDTH),
      .USER_W (C_TUSER_WIDTH)
   ) u_slice_0 (
      .clk_i    (main_clock),
      .rst_i    (main_reset),
      .load_i   (load[0]),
      .tdata_i  (axi4s_vid_in_tdata),
      .tlast_i  (axi4s_vid_in_tlast),
      .tuser_i  (fwd_user),
      .tready_i (axi4s_vid_out_0_tready),
      .tvalid_o (slc_vld[0]),
      .tdata_o  (axi4s_vid_out_0_tdata),
      .tlast_o  (axi4s_vid_out_0_tlast),
      .tuser_o  (axi4s_vid_out_0_tuser)
   );

   intel_vvp_exposure_deinterleave_slice #(
      .DATA_W (C_AXIS_WIDTH),
      .USER_W (C_TUSER_WIDTH)
   ) u_slice_1 (
      .clk_i    (main_clock),
      .rst_i    (main_reset),
      .load_i   (load[1]),
      .tdata_i  (axi4s_vid_in_tdata),
      .tlast_i  (axi4s_vid_in_tlast),
      .tuser_i  (fwd_user),
      .tready_i (axi4s_vid_out_1_tready),
      .tvalid_o (slc_vld[1]),
      .tdata_o  (axi4s_vid_out_1_tdata),
      .tlast_o  (axi4s_vid_out_1_tlast),
      .tuser_o  (axi4s_vid_out_1_tuser)
   );

   assign axi4s_vid_out_0_tvalid = slc_vld[0];
   assign axi4s_vid_out_1_tvalid = slc_vld[1];

endmodule

// File: tb/tb_intel_vvp_exposure_deinterleave.sv
// Bench for the exposure deinterleaver: dut A (first line -> out_0), dut B (first line -> out_1).
// Both see the same input stream; each has its own queue-based reference of expected output beats.
// Outputs are sampled 1 time unit after the falling edge, inputs change on the falling edge.
module tb_intel_vvp_exposure_deinterleave;
   localparam int W = 32;
   localparam int U = 4;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
      logic [U-1:0] u;
      int           cyc;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [W-1:0] in_d;
   logic         in_l;
   logic [U-1:0] in_u;
   logic         in_v;
   logic         a_ir, b_ir;
   logic [W-1:0] a0_d, a1_d, b0_d, b1_d;
   logic         a0_l, a1_l, b0_l, b1_l;
   logic [U-1:0] a0_u, a1_u, b0_u, b1_u;
   logic         a0_v, a1_v, b0_v, b1_v;
   logic         a0_r, a1_r;
   logic         a_err, b_err;

   intel_vvp_exposure_deinterleave dut_a (
      .main_clock(clk), .main_reset(rst),
      .axi4s_vid_in_tdata(in_d), .axi4s_vid_in_tlast(in_l), .axi4s_vid_in_tuser(in_u),
      .axi4s_vid_in_tvalid(in_v), .axi4s_vid_in_tready(a_ir),
      .axi4s_vid_out_0_tdata(a0_d), .axi4s_vid_out_0_tlast(a0_l), .axi4s_vid_out_0_tuser(a0_u),
      .axi4s_vid_out_0_tvalid(a0_v), .axi4s_vid_out_0_tready(a0_r),
      .axi4s_vid_out_1_tdata(a1_d), .axi4s_vid_out_1_tlast(a1_l), .axi4s_vid_out_1_tuser(a1_u),
      .axi4s_vid_out_1_tvalid(a1_v), .axi4s_vid_out_1_tready(a1_r),
      .status_sof_error(a_err)
   );

   intel_vvp_exposure_deinterleave #(.C_FIRST_LINE_EXPOSURE(1)) dut_b (
      .main_clock(clk), .main_reset(rst),
      .axi4s_vid_in_tdata(in_d), .axi4s_vid_in_tlast(in_l), .axi4s_vid_in_tuser(in_u),
      .axi4s_vid_in_tvalid(in_v), .axi4s_vid_in_tready(b_ir),
      .axi4s_vid_out_0_tdata(b0_d), .axi4s_vid_out_0_tlast(b0_l), .axi4s_vid_out_0_tuser(b0_u),
      .axi4s_vid_out_0_tvalid(b0_v), .axi4s_vid_out_0_tready(1'b1),
      .axi4s_vid_out_1_tdata(b1_d), .axi4s_vid_out_1_tlast(b1_l), .axi4s_vid_out_1_tuser(b1_u),
      .axi4s_vid_out_1_tvalid(b1_v), .axi4s_vid_out_1_tready(1'b1),
      .status_sof_error(b_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cnt[4];
   int sofcnt[4];
   int stall_a = 0;
   int a_err_pulses = 0;
   int hold1 = 0;
   bit rnd_rdy = 0;
   bit lat_chk = 0;
   bit acc_a = 0;

   // reference state, per dut
   bit       first_exp[2] = '{1'b0, 1'b1};
   bit       synced[2];
   bit       cur_out[2];
   bit       line_start[2];
   bit [1:0] pend[2];
   bit       err_exp[2];
   ent_t     q0[$], q1[$], q2[$], q3[$];

   task automatic clear_counts();
      for (int k = 0; k < 4; k++) begin cnt[k] = 0; sofcnt[k] = 0; end
      stall_a = 0;
      a_err_pulses = 0;
   endtask

   task automatic model_reset();
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      for (int d = 0; d < 2; d++) begin
         synced[d] = 0; cur_out[d] = first_exp[d]; line_start[d] = 1; pend[d] = 2'b00; err_exp[d] = 0;
      end
   endtask

   task automatic push(input int k, input ent_t e);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   // One accepted input beat, as seen by dut d.
   task automatic model_accept(input int d);
      ent_t e;
      bit   sof;
      bit   tgt;
      sof = in_u[0];
      err_exp[d] = 1'b0;
      if (!synced[d] && !sof) return;
      if (sof) begin
         err_exp[d] = synced[d] && !line_start[d];
         synced[d]  = 1;
         tgt        = first_exp[d];
         pend[d]    = 2'b11;
      end else begin
         tgt = cur_out[d];
      end
      e.d = in_d; e.l = in_l; e.u = in_u; e.u[0] = pend[d][tgt]; e.cyc = cyc;
      pend[d][tgt] = 1'b0;
      push(d * 2 + int'(tgt), e);
      cur_out[d]    = in_l ? !tgt : tgt;
      line_start[d] = in_l;
   endtask

   task automatic pop_chk(input int k, input logic [W-1:0] d, input logic l, input logic [U-1:0] u);
      ent_t e;
      int   n;
      case (k)
         0: n = q0.size();
         1: n = q1.size();
         2: n = q2.size();
         default: n = q3.size();
      endcase
      checks++;
      if (n == 0) begin
         errors++;
         $display("FAIL unexpected_beat port%0d got d=%h required none", k, d);
         return;
      end
      case (k)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         2: e = q2.pop_front();
         default: e = q3.pop_front();
      endcase
      if (d !== e.d || l !== e.l || u !== e.u) begin
         errors++;
         $display("FAIL beat port%0d got d=%h l=%b u=%h required d=%h l=%b u=%h", k, d, l, u, e.d, e.l, e.u);
      end
      if (k >= 2 || lat_chk) begin
         checks++;
         if (cyc - e.cyc != 1) begin
            errors++;
            $display("FAIL latency port%0d got %0d required 1", k, cyc - e.cyc);
         end
      end
      cnt[k]++;
      if (u[0] === 1'b1) sofcnt[k]++;
   endtask

   // Advance one clock: drive readies, sample just before the rising edge, update the reference.
   task automatic tick();
      logic [W-1:0] od[4];
      logic         ol[4];
      logic [U-1:0] ou[4];
      logic         ov[4];
      logic         orr[4];
      logic         eo[2];
      if (hold1 > 0) begin
         a0_r = 1'b1; a1_r = 1'b0; hold1--;
      end else if (rnd_rdy) begin
         a0_r = ($urandom_range(0, 3) != 0); a1_r = ($urandom_range(0, 3) != 0);
      end else begin
         a0_r = 1'b1; a1_r = 1'b1;
      end
      #1;
      cyc++;
      acc_a = 0;
      eo[0] = a_err; eo[1] = b_err;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (eo[d] !== err_exp[d]) begin
            errors++;
            $display("FAIL sof_error dut%0d got %b required %b at cycle %0d", d, eo[d], err_exp[d], cyc);
         end
      end
      if (a_err === 1'b1) a_err_pulses++;
      if (rst) begin
         model_reset();
      end else begin
         od = '{a0_d, a1_d, b0_d, b1_d};
         ol = '{a0_l, a1_l, b0_l, b1_l};
         ou = '{a0_u, a1_u, b0_u, b1_u};
         ov = '{a0_v, a1_v, b0_v, b1_v};
         orr = '{a0_r, a1_r, 1'b1, 1'b1};
         for (int k = 0; k < 4; k++)
            if (ov[k] === 1'b1 && orr[k] === 1'b1) pop_chk(k, od[k], ol[k], ou[k]);
         if (in_v && a_ir === 1'b1) begin model_accept(0); acc_a = 1; end
         else err_exp[0] = 1'b0;
         if (in_v && b_ir === 1'b1) model_accept(1);
         else err_exp[1] = 1'b0;
         if (in_v && a_ir !== 1'b1) stall_a++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_v = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input logic [W-1:0] d, input logic last, input logic sof);
      int n = 0;
      in_v = 1'b1; in_d = d; in_l = last; in_u = {3'($urandom_range(0, 7)), sof};
      do begin tick(); n++; end while (!acc_a && n < 200);
      in_v = 1'b0;
      if (!acc_a) begin
         checks++; errors++;
         $display("FAIL send_timeout got no accept after %0d cycles required accept", n);
      end
   endtask

   task automatic frame(input int lines, input int beats, input bit rnd_data, input bit gaps);
      for (int l = 0; l < lines; l++)
         for (int b = 0; b < beats; b++) begin
            send(rnd_data ? W'($urandom) : W'(l * 16 + b), b == beats - 1, l == 0 && b == 0);
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
         end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_counts();
   endtask

   task automatic check_drained(input string name);
      idle(4);
      checks++;
      if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d/%0d/%0d/%0d beats outstanding required 0",
                  name, q0.size(), q1.size(), q2.size(), q3.size());
      end
   endtask

   task automatic chk_int(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_v = 1'b0; in_d = '0; in_l = 1'b0; in_u = '0; a0_r = 1'b1; a1_r = 1'b1;
      model_reset();
      clear_counts();
      @(negedge clk);
      #1;
      chk_int("reset_in_tready_a", int'(a_ir), 0);
      chk_int("reset_in_tready_b", int'(b_ir), 0);
      chk_int("reset_tvalid_a", int'({a1_v, a0_v}), 0);
      chk_int("reset_tvalid_b", int'({b1_v, b0_v}), 0);
      chk_int("reset_sof_error", int'({b_err, a_err}), 0);
      tick();
      rst = 1'b0;
      #1;
      chk_int("wait_sof_in_tready", int'(a_ir), 1);
      idle(2);
   endtask

   task automatic test_basic_frame();
      lat_chk = 1;
      clear_counts();
      frame(4, 4, 0, 0);
      idle(3);
      chk_int("basic_out0_beats", cnt[0], 8);
      chk_int("basic_out1_beats", cnt[1], 8);
      chk_int("basic_out0_sof", sofcnt[0], 1);
      chk_int("basic_out1_sof", sofcnt[1], 1);
      check_drained("basic");
   endtask

   task automatic test_pre_sof_discard();
      do_reset();
      lat_chk = 1;
      for (int i = 0; i < 5; i++) begin
         in_v = 1'b1; in_d = $urandom; in_l = (i == 2); in_u = {3'($urandom_range(0, 7)), 1'b0};
         tick();
      end
      idle(3);
      chk_int("presof_discarded", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
      chk_int("presof_no_stall", stall_a, 0);
      frame(2, 3, 1, 0);
      idle(2);
      chk_int("presof_out0_beats", cnt[0], 3);
      chk_int("presof_out1_beats", cnt[1], 3);
      check_drained("presof");
   endtask

   task automatic test_backpressure();
      do_reset();
      lat_chk = 0;
      for (int l = 0; l < 4; l++)
         for (int b = 0; b < 4; b++) begin
            if (l == 1 && b == 0) begin stall_a = 0; hold1 = 10; end
            send(W'(l * 16 + b), b == 3, l == 0 && b == 0);
         end
      idle(12);
      chk_int("bp_stall_cycles", stall_a, 9);
      chk_int("bp_out0_beats", cnt[0], 8);
      chk_int("bp_out1_beats", cnt[1], 8);
      check_drained("bp");
   endtask

   task automatic test_early_sof();
      do_reset();
      lat_chk = 1;
      for (int b = 0; b < 4; b++) send(W'(b), b == 3, b == 0);
      send(W'(16), 1'b0, 1'b0);
      send(W'(17), 1'b0, 1'b0);
      send(W'(18), 1'b0, 1'b1);
      send(W'(19), 1'b1, 1'b0);
      for (int l = 2; l < 4; l++)
         for (int b = 0; b < 4; b++) send(W'(l * 16 + b), b == 3, 1'b0);
      idle(3);
      chk_int("early_sof_pulses", a_err_pulses, 1);
      chk_int("early_out0_beats", cnt[0], 10);
      chk_int("early_out1_beats", cnt[1], 6);
      chk_int("early_out0_sof", sofcnt[0], 2);
      chk_int("early_out1_sof", sofcnt[1], 2);
      check_drained("early");
   endtask

   task automatic test_mid_reset();
      do_reset();
      lat_chk = 1;
      frame(2, 4, 1, 0);
      send($urandom, 1'b0, 1'b0);
      send($urandom, 1'b0, 1'b0);
      in_v = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_v = 1'b0;
      clear_counts();
      #1;
      chk_int("midrst_tvalid_a", int'({a1_v, a0_v}), 0);
      chk_int("midrst_tvalid_b", int'({b1_v, b0_v}), 0);
      for (int i = 0; i < 3; i++) send($urandom, i == 1, 1'b0);
      idle(3);
      chk_int("midrst_discarded", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
      frame(2, 4, 1, 0);
      idle(2);
      chk_int("midrst_out0_beats", cnt[0], 4);
      chk_int("midrst_out1_beats", cnt[1], 4);
      check_drained("midrst");
   endtask

   task automatic test_first_line_one();
      do_reset();
      lat_chk = 1;
      frame(2, 4, 1, 0);
      idle(3);
      chk_int("first1_out1_beats", cnt[3], 4);
      chk_int("first1_out0_beats", cnt[2], 4);
      chk_int("first1_out1_sof", sofcnt[3], 1);
      chk_int("first1_out0_sof", sofcnt[2], 1);
      check_drained("first1");
   endtask

   task automatic test_back_to_back();
      int total = 0;
      int nl, nb;
      do_reset();
      lat_chk = 0;
      rnd_rdy = 1;
      for (int f = 0; f < 8; f++) begin
         nl = $urandom_range(1, 4);
         nb = $urandom_range(1, 4);
         frame(nl, nb, 1, 1);
         total += nl * nb;
      end
      rnd_rdy = 0;
      idle(4);
      chk_int("b2b_total_a", cnt[0] + cnt[1], total);
      check_drained("b2b");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_pre_sof_discard();
      test_backpressure();
      test_early_sof();
      test_mid_reset();
      test_first_line_one();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
